// File: rtl/instruction_fetch.sv
// Fetch stage of the tile-game CPU: drives the PC into the combinational ROM,
// registers issued instructions for decode, and resolves JMP/CALL locally,
// BLE/RET through a wait-for-resolution handshake, and NOP N as a fetch delay.
module instruction_fetch (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oInstructionAddress,
    input  logic [29:0] iInstruction,
    output logic [29:0] oInstruction,
    output logic        oInstructionValid,
    output logic [15:0] oInstructionPC,
    input  logic        iStall,
    output logic        oCallWrite,
    output logic [15:0] oReturnAddress,
    input  logic        iBranchResolved,
    input  logic        iBranchTaken,
    input  logic        iReturnValid,
    input  logic [15:0] iReturnTarget
);

    // Opcode values shared with the rest of the CPU (Defintions.v)
    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_JMP  = 6'h10;
    localparam logic [5:0] OP_CALL = 6'h11;
    localparam logic [5:0] OP_BLE  = 6'h12;
    localparam logic [5:0] OP_RET  = 6'h13;

    typedef enum logic [1:0] {
        FETCH,
        DELAY,
        WAIT_BRANCH,
        WAIT_RET
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc, pc_next;
    logic [23:0] counter, counter_next;
    logic        issue;
    logic        call_issue;

    logic [5:0]  opcode;
    logic [15:0] target;
    logic [15:0] held_target;
    logic [23:0] literal;

    assign opcode      = iInstruction[29:24];
    assign target      = {8'h00, iInstruction[23:16]};
    assign literal     = iInstruction[23:0];
    // oInstruction only changes on issue, so it still holds the waiting BLE
    assign held_target = {8'h00, oInstruction[23:16]};

    assign oInstructionAddress = pc;

    // Next-state, next-PC and issue decision
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        counter_next = counter;
        issue        = 1'b0;
        call_issue   = 1'b0;
        case (state)
            FETCH: begin
                if (!iStall) begin
                    issue   = 1'b1;
                    pc_next = pc + 16'd1;
                    case (opcode)
                        OP_JMP: pc_next = target;
                        OP_CALL: begin
                            pc_next    = target;
                            call_issue = 1'b1;
                        end
                        OP_BLE: begin
                            pc_next    = pc;
                            state_next = WAIT_BRANCH;
                        end
                        OP_RET: begin
                            pc_next    = pc;
                            state_next = WAIT_RET;
                        end
                        OP_NOP: begin
                            if (literal != 24'd0) begin
                                counter_next = literal;
                                state_next   = DELAY;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DELAY: begin
                counter_next = counter - 24'd1;
                if (counter <= 24'd1) begin
                    state_next = FETCH;
                end
            end
            WAIT_BRANCH: begin
                if (iBranchResolved) begin
                    pc_next    = iBranchTaken ? held_target : pc + 16'd1;
                    state_next = FETCH;
                end
            end
            WAIT_RET: begin
                if (iReturnValid) begin
                    pc_next    = iReturnTarget;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Control state: FSM state, program counter and delay counter
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= FETCH;
            pc      <= '0;
            counter <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            counter <= counter_next;
        end
    end

    // Decode-facing registers: issued instruction, acceptance and CALL pulse
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oInstruction      <= '0;
            oInstructionPC    <= '0;
            oInstructionValid <= 1'b0;
            oCallWrite        <= 1'b0;
            oReturnAddress    <= '0;
        end else begin
            oCallWrite <= call_issue;
            if (issue) begin
                oInstruction      <= iInstruction;
                oInstructionPC    <= pc;
                oInstructionValid <= 1'b1;
            end else if (!iStall) begin
                oInstructionValid <= 1'b0;
            end
            if (call_issue) begin
                oReturnAddress <= pc + 16'd1;
            end
        end
    end

endmodule
